// File: rtl/sa_config_sequencer.sv
// Configuration sequencer for the systolic array: walks a list of ROM configuration
// words, drives the clear/load/run/drain phases of the PE array and decodes per-row fields.
module sa_config_sequencer #(
   parameter int N_ROWS_ARRAY    = 4,
   parameter int N               = 3,
   parameter int SEL_WIDTH       = $clog2(N),
   parameter int NUM_COL_WIDTH   = $clog2(N + 1),
   parameter int ROM_SIG_WIDTH   = 100,
   parameter int SIG_ADDRS_WIDTH = 10,
   parameter int CNT_WIDTH       = 12,
   parameter int DRAIN_CYCLES    = 4
) (
   input  logic                                  clk_i,
   input  logic                                  general_rst_i,
   input  logic                                  start_i,
   input  logic                                  abort_i,
   input  logic [NUM_COL_WIDTH-1:0]              filter_size_i,
   input  logic [SIG_ADDRS_WIDTH-1:0]            n_configs_i,
   input  logic [CNT_WIDTH-1:0]                  load_len_i,
   input  logic [CNT_WIDTH-1:0]                  run_len_i,
   input  logic [ROM_SIG_WIDTH-1:0]              rom_signals_data_i,
   output logic                                  busy_o,
   output logic                                  done_o,
   output logic                                  rst_o,
   output logic                                  load_o,
   output logic                                  start_op_o,
   output logic                                  rd_rom_signals_ld_o,
   output logic [SIG_ADDRS_WIDTH-1:0]            addrs_rom_signal_o,
   output logic                                  rd_weight_ld_o,
   output logic                                  rd_feature_ld_o,
   output logic [N_ROWS_ARRAY*SEL_WIDTH-1:0]     f_sel_o,
   output logic [N_ROWS_ARRAY*NUM_COL_WIDTH-1:0] number_of_columns_o,
   output logic [N_ROWS_ARRAY*NUM_COL_WIDTH-1:0] row_num_o,
   output logic [N_ROWS_ARRAY*NUM_COL_WIDTH-1:0] column_num_o,
   output logic [2:0]                            state_dbg_o
);

   localparam int SW = N_ROWS_ARRAY * SEL_WIDTH;
   localparam int CWF = N_ROWS_ARRAY * NUM_COL_WIDTH;
   localparam int USED_BITS = SW + CWF;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_CLR   = 3'd1,
      S_FETCH = 3'd2,
      S_LATCH = 3'd3,
      S_LOAD  = 3'd4,
      S_RUN   = 3'd5,
      S_DRAIN = 3'd6,
      S_DONE  = 3'd7
   } state_e;

   state_e                     state_q, state_d;
   logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
   logic [SIG_ADDRS_WIDTH-1:0] addr_q, addr_d;
   logic [SIG_ADDRS_WIDTH-1:0] ncfg_q, ncfg_d;
   logic [NUM_COL_WIDTH-1:0]   fs_q, fs_d;
   logic [CNT_WIDTH-1:0]       load_len_q, load_len_d;
   logic [CNT_WIDTH-1:0]       run_len_q, run_len_d;
   logic [SW-1:0]              f_sel_q, f_sel_d;
   logic [CWF-1:0]             ncols_q, ncols_d;
   logic [CWF-1:0]             col_q, col_d;
   logic [CWF-1:0]             row_q, row_d;
   logic                       busy_q, busy_d;
   logic                       done_q, done_d;
   logic                       rst_q, rst_d;
   logic                       load_q, load_d;
   logic                       run_q, run_d;
   logic                       rd_rom_q, rd_rom_d;

   logic [NUM_COL_WIDTH-1:0]   fs_eff;
   logic [NUM_COL_WIDTH-1:0]   row_cnt;
   logic [NUM_COL_WIDTH-1:0]   col_off;
   logic [NUM_COL_WIDTH-1:0]   nc_field;
   logic [NUM_COL_WIDTH-1:0]   col_val;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      ncfg_d     = ncfg_q;
      fs_d       = fs_q;
      load_len_d = load_len_q;
      run_len_d  = run_len_q;
      f_sel_d    = f_sel_q;
      ncols_d    = ncols_q;
      col_d      = col_q;
      row_d      = row_q;
      fs_eff     = filter_size_i;
      row_cnt    = '0;
      col_off    = '0;
      nc_field   = '0;
      col_val    = '0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (filter_size_i == '0 || filter_size_i > NUM_COL_WIDTH'(N)) begin
                  fs_eff = NUM_COL_WIDTH'(N);
               end
               fs_d       = fs_eff;
               ncfg_d     = (n_configs_i == '0) ? SIG_ADDRS_WIDTH'(1) : n_configs_i;
               load_len_d = (load_len_i == '0) ? CNT_WIDTH'(1) : load_len_i;
               run_len_d  = (run_len_i == '0) ? CNT_WIDTH'(1) : run_len_i;
               addr_d     = '0;
               state_d    = S_CLR;
               // Row index cycles 1..filter_size down the array.
               row_cnt = NUM_COL_WIDTH'(1);
               for (int i = 0; i < N_ROWS_ARRAY; i++) begin
                  row_d[i*NUM_COL_WIDTH +: NUM_COL_WIDTH] = row_cnt;
                  row_cnt = (row_cnt == fs_eff) ? NUM_COL_WIDTH'(1) : row_cnt + NUM_COL_WIDTH'(1);
               end
            end
         end
         S_CLR:   state_d = S_FETCH;
         S_FETCH: state_d = S_LATCH;
         S_LATCH: begin
            // Running offset resets whenever a row lands on column 1.
            col_off = '0;
            for (int i = 0; i < N_ROWS_ARRAY; i++) begin
               f_sel_d[i*SEL_WIDTH +: SEL_WIDTH] = rom_signals_data_i[i*SEL_WIDTH +: SEL_WIDTH];
               nc_field = rom_signals_data_i[SW + i*NUM_COL_WIDTH +: NUM_COL_WIDTH];
               ncols_d[i*NUM_COL_WIDTH +: NUM_COL_WIDTH] = nc_field;
               col_val = nc_field - col_off;
               col_d[i*NUM_COL_WIDTH +: NUM_COL_WIDTH] = col_val;
               col_off = (col_val == NUM_COL_WIDTH'(1)) ? '0 : col_off + NUM_COL_WIDTH'(1);
            end
            cnt_d   = load_len_q - CNT_WIDTH'(1);
            state_d = S_LOAD;
         end
         S_LOAD: begin
            if (cnt_q == '0) begin
               cnt_d   = run_len_q - CNT_WIDTH'(1);
               state_d = S_RUN;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         S_RUN: begin
            if (cnt_q == '0) begin
               cnt_d   = CNT_WIDTH'(DRAIN_CYCLES - 1);
               state_d = S_DRAIN;
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         S_DRAIN: begin
            if (cnt_q == '0) begin
               if (addr_q == ncfg_q - SIG_ADDRS_WIDTH'(1)) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = addr_q + SIG_ADDRS_WIDTH'(1);
                  state_d = S_CLR;
               end
            end else begin
               cnt_d = cnt_q - CNT_WIDTH'(1);
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Abort wins over any phase transition; decoded fields keep their old values.
      if (abort_i && state_q != S_IDLE && state_q != S_DONE) begin
         state_d = S_IDLE;
         f_sel_d = f_sel_q;
         ncols_d = ncols_q;
         col_d   = col_q;
      end

      busy_d   = (state_d != S_IDLE);
      done_d   = (state_d == S_DONE);
      rst_d    = (state_d == S_CLR);
      rd_rom_d = (state_d == S_FETCH);
      load_d   = (state_d == S_LOAD);
      run_d    = (state_d == S_RUN);
   end

   always_ff @(posedge clk_i) begin
      if (general_rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         ncfg_q     <= '0;
         fs_q       <= '0;
         load_len_q <= '0;
         run_len_q  <= '0;
         f_sel_q    <= '0;
         ncols_q    <= '0;
         col_q      <= '0;
         row_q      <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         rst_q      <= 1'b0;
         load_q     <= 1'b0;
         run_q      <= 1'b0;
         rd_rom_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         ncfg_q     <= ncfg_d;
         fs_q       <= fs_d;
         load_len_q <= load_len_d;
         run_len_q  <= run_len_d;
         f_sel_q    <= f_sel_d;
         ncols_q    <= ncols_d;
         col_q      <= col_d;
         row_q      <= row_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         rst_q      <= rst_d;
         load_q     <= load_d;
         run_q      <= run_d;
         rd_rom_q   <= rd_rom_d;
      end
   end

   generate
      if (ROM_SIG_WIDTH > USED_BITS) begin : g_rom_spare
         logic unused_rom_bits;
         assign unused_rom_bits = ^rom_signals_data_i[ROM_SIG_WIDTH-1:USED_BITS];
      end
   endgenerate

   assign busy_o              = busy_q;
   assign done_o              = done_q;
   assign rst_o               = rst_q;
   assign load_o              = load_q;
   assign rd_weight_ld_o      = load_q;
   assign start_op_o          = run_q;
   assign rd_feature_ld_o     = run_q;
   assign rd_rom_signals_ld_o = rd_rom_q;
   assign addrs_rom_signal_o  = addr_q;
   assign f_sel_o             = f_sel_q;
   assign number_of_columns_o = ncols_q;
   assign row_num_o           = row_q;
   assign column_num_o        = col_q;
   assign state_dbg_o         = state_q;

endmodule

// File: tb/tb_sa_config_sequencer.sv
// Directed bench for sa_config_sequencer: phase timing, row/column decode table,
// multi-config walk, abort and mid-sequence reset.
module tb_sa_config_sequencer;

   localparam int AW  = 10;
   localparam int CW  = 12;
   localparam int RSW = 100;
   localparam int DC  = 4;

   logic           clk = 1'b0;
   logic           general_rst_i = 1'b1;
   logic           start_i = 1'b0;
   logic           abort_i = 1'b0;
   logic [1:0]     filter_size_i = '0;
   logic [AW-1:0]  n_configs_i = '0;
   logic [CW-1:0]  load_len_i = '0;
   logic [CW-1:0]  run_len_i = '0;
   logic [RSW-1:0] rom_data = '0;
   logic           busy_o, done_o, rst_o, load_o, start_op_o, rd_rom_o;
   logic           rd_weight_o, rd_feature_o;
   logic [AW-1:0]  addr_o;
   logic [7:0]     f_sel_o, ncols_o, row_o, col_o;
   logic [2:0]     state_o;

   always #5 clk = ~clk;

   sa_config_sequencer dut (
      .clk_i               (clk),
      .general_rst_i       (general_rst_i),
      .start_i             (start_i),
      .abort_i             (abort_i),
      .filter_size_i       (filter_size_i),
      .n_configs_i         (n_configs_i),
      .load_len_i          (load_len_i),
      .run_len_i           (run_len_i),
      .rom_signals_data_i  (rom_data),
      .busy_o              (busy_o),
      .done_o              (done_o),
      .rst_o               (rst_o),
      .load_o              (load_o),
      .start_op_o          (start_op_o),
      .rd_rom_signals_ld_o (rd_rom_o),
      .addrs_rom_signal_o  (addr_o),
      .rd_weight_ld_o      (rd_weight_o),
      .rd_feature_ld_o     (rd_feature_o),
      .f_sel_o             (f_sel_o),
      .number_of_columns_o (ncols_o),
      .row_num_o           (row_o),
      .column_num_o        (col_o),
      .state_dbg_o         (state_o)
   );

   // ROM model: data valid the cycle after the read enable.
   logic [RSW-1:0] rom_mem [0:7];
   always @(posedge clk) if (rd_rom_o) rom_data <= rom_mem[addr_o[2:0]];

   typedef struct {
      logic [1:0] fs;
      logic [7:0] fsel;
      logic [7:0] ncols;
      logic [7:0] exp_row;
      logic [7:0] exp_col;
   } vec_t;
   vec_t vecs[5];

   int total = 0;
   int bad = 0;
   int rst_cnt, done_cnt, cyc;
   logic [AW-1:0] exp_q[$];
   logic [AW-1:0] got_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   function automatic logic [RSW-1:0] rom_word(input logic [7:0] nc, input logic [7:0] fs);
      rom_word = {84'd0, nc, fs};
   endfunction

   // {busy, done, rst, rd_rom, load, rd_weight, start_op, rd_feature} expected in cycle k after start.
   function automatic logic [7:0] exp_strobes(input int k, input int l, input int r);
      int last;
      logic ld, rn;
      last = 3 + l + r + DC;
      ld = (k >= 4) && (k < 4 + l);
      rn = (k >= 4 + l) && (k < 4 + l + r);
      exp_strobes = {(k >= 1 && k <= last + 1), (k == last + 1), (k == 1), (k == 2), ld, ld, rn, rn};
   endfunction

   function automatic logic [63:0] all_outs();
      all_outs = {14'd0, busy_o, done_o, rst_o, load_o, start_op_o, rd_rom_o, rd_weight_o,
                  rd_feature_o, addr_o, f_sel_o, ncols_o, row_o, col_o};
   endfunction

   task automatic do_start(input logic [1:0] fs, input logic [AW-1:0] nc,
                           input logic [CW-1:0] ll, input logic [CW-1:0] rl);
      filter_size_i = fs;
      n_configs_i   = nc;
      load_len_i    = ll;
      run_len_i     = rl;
      start_i       = 1'b1;
      tick();
      start_i       = 1'b0;
   endtask

   task automatic run_to_idle(input int max_cyc, input int poke_at);
      int n;
      n = 0;
      rst_cnt = 0;
      done_cnt = 0;
      got_q.delete();
      while (busy_o && n < max_cyc) begin
         if (rst_o) rst_cnt++;
         if (done_o) done_cnt++;
         if (rd_rom_o) got_q.push_back(addr_o);
         start_i = (n == poke_at);
         n++;
         tick();
      end
      start_i = 1'b0;
      cyc = n;
      chk("idle_timeout", {63'd0, busy_o}, 64'd0);
   endtask

   initial begin
      int sc;
      vecs[0] = '{2'd3, 8'hE4, 8'h7F, 8'h79, 8'h5B};
      vecs[1] = '{2'd2, 8'h1B, 8'hAA, 8'h99, 8'h66};
      vecs[2] = '{2'd0, 8'h00, 8'h55, 8'h79, 8'h55};
      vecs[3] = '{2'd1, 8'hFF, 8'h00, 8'h55, 8'h6C};
      vecs[4] = '{2'd2, 8'h36, 8'hE7, 8'h99, 8'h03};
      for (int i = 0; i < 8; i++) rom_mem[i] = '0;

      // Reset state
      repeat (3) tick();
      chk("reset_outs", all_outs(), 64'd0);
      chk("reset_state", {61'd0, state_o}, 64'd0);
      general_rst_i = 1'b0;
      tick();

      // Phase timing, one config, L=4 R=6
      rom_mem[0] = rom_word(8'h7F, 8'hE4);
      do_start(2'd3, 10'd1, 12'd4, 12'd6);
      for (int k = 1; k <= 19; k++) begin
         chk($sformatf("strobes_c%0d", k),
             {56'd0, busy_o, done_o, rst_o, rd_rom_o, load_o, rd_weight_o, start_op_o, rd_feature_o},
             {56'd0, exp_strobes(k, 4, 6)});
         if (k == 2) chk("fetch_addr0", {54'd0, addr_o}, 64'd0);
         tick();
      end

      // Decode table
      for (int v = 0; v < 5; v++) begin
         rom_mem[0] = rom_word(vecs[v].ncols, vecs[v].fsel);
         do_start(vecs[v].fs, 10'd1, 12'd1, 12'd1);
         run_to_idle(100, -1);
         chk($sformatf("v%0d_row", v), {56'd0, row_o}, {56'd0, vecs[v].exp_row});
         chk($sformatf("v%0d_col", v), {56'd0, col_o}, {56'd0, vecs[v].exp_col});
         chk($sformatf("v%0d_ncols", v), {56'd0, ncols_o}, {56'd0, vecs[v].ncols});
         chk($sformatf("v%0d_fsel", v), {56'd0, f_sel_o}, {56'd0, vecs[v].fsel});
         chk($sformatf("v%0d_done", v), 64'(done_cnt), 64'd1);
         chk($sformatf("v%0d_cycles", v), 64'(cyc), 64'(3 + 1 + 1 + DC + 1));
      end

      // Zero counts/lengths clamp to 1
      do_start(2'd3, 10'd0, 12'd0, 12'd0);
      run_to_idle(100, -1);
      chk("zero_cycles", 64'(cyc), 64'(3 + 1 + 1 + DC + 1));
      chk("zero_reads", 64'(got_q.size()), 64'd1);

      // Three configs, stray start mid-sequence
      rom_mem[0] = rom_word(8'h55, 8'h00);
      rom_mem[1] = rom_word(8'hAA, 8'h1B);
      rom_mem[2] = rom_word(8'h7F, 8'hE4);
      do_start(2'd3, 10'd3, 12'd4, 12'd6);
      run_to_idle(200, 20);
      for (int i = 0; i < 3; i++) exp_q.push_back(AW'(i));
      chk("multi_nreads", 64'(got_q.size()), 64'd3);
      while (exp_q.size() > 0 && got_q.size() > 0)
         chk("multi_addr", {54'd0, got_q.pop_front()}, {54'd0, exp_q.pop_front()});
      exp_q.delete();
      chk("multi_clr", 64'(rst_cnt), 64'd3);
      chk("multi_done", 64'(done_cnt), 64'd1);
      chk("multi_cycles", 64'(cyc), 64'(3 * 17 + 1));
      chk("multi_col_last", {56'd0, col_o}, 64'h5B);
      tick();
      chk("multi_stays_idle", {63'd0, busy_o}, 64'd0);

      // Abort in RUN cycle 3
      rom_mem[0] = rom_word(8'h7F, 8'hE4);
      do_start(2'd3, 10'd1, 12'd4, 12'd6);
      sc = 0;
      for (int n = 0; n < 40 && sc < 3; n++) begin
         if (start_op_o) sc++;
         if (sc < 3) tick();
      end
      chk("abort_reached_run3", 64'(sc), 64'd3);
      abort_i = 1'b1;
      tick();
      abort_i = 1'b0;
      chk("abort_busy", {63'd0, busy_o}, 64'd0);
      chk("abort_start_op", {63'd0, start_op_o}, 64'd0);
      chk("abort_state", {61'd0, state_o}, 64'd0);
      chk("abort_col_held", {56'd0, col_o}, 64'h5B);
      done_cnt = 0;
      for (int n = 0; n < 20; n++) begin
         if (done_o || busy_o) done_cnt++;
         tick();
      end
      chk("abort_no_done", 64'(done_cnt), 64'd0);

      // Reset during LOAD, then replay from addr 0 (start with abort in IDLE: start wins)
      do_start(2'd3, 10'd2, 12'd4, 12'd6);
      for (int n = 0; n < 10 && !load_o; n++) tick();
      chk("rst_in_load", {63'd0, load_o}, 64'd1);
      general_rst_i = 1'b1;
      tick();
      general_rst_i = 1'b0;
      chk("rst_outs", all_outs(), 64'd0);
      chk("rst_state", {61'd0, state_o}, 64'd0);
      abort_i = 1'b1;
      do_start(2'd2, 10'd2, 12'd1, 12'd1);
      abort_i = 1'b0;
      chk("start_beats_abort", {63'd0, busy_o}, 64'd1);
      run_to_idle(100, -1);
      chk("replay_nreads", 64'(got_q.size()), 64'd2);
      if (got_q.size() > 0) chk("replay_first_addr", {54'd0, got_q[0]}, 64'd0);
      chk("replay_row", {56'd0, row_o}, 64'h99);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
